// File: rtl/ap_ctrl_sequencer.sv
// Batch sequencer for an ap_ctrl_hs kernel: issues up to MAX_OUTST overlapping starts and counts dones.
// Optional idle watchdog enabled by defining AP_CTRL_SEQ_TIMEOUT_EN.
module ap_ctrl_sequencer #(
    parameter int unsigned MAX_OUTST      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_req,
    input  logic [15:0] num_trans,
    output logic        ap_start,
    input  logic        ap_ready,
    input  logic        ap_done,
    output logic        ap_continue,
    output logic        busy,
    output logic        finish,
    output logic [15:0] issued_cnt,
    output logic [15:0] done_cnt,
    output logic [31:0] total_cycles,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_e;

    localparam logic [15:0] MAX_OUTST_W = 16'(MAX_OUTST);

    state_e      state_q;
    logic [15:0] num_q;
    logic [15:0] issued_q;
    logic [15:0] done_q;
    logic [31:0] cycles_q;

    logic        active;
    logic [15:0] outst;
    logic        issue_fire;
    logic        done_fire;
    logic [15:0] issued_d;
    logic [15:0] done_d;
    logic        wd_expire;

    assign active = (state_q == ISSUE) || (state_q == DRAIN);

    // Spurious dones can push done_q past issued_q; clamp so the window never wraps.
    assign outst      = (issued_q > done_q) ? (issued_q - done_q) : 16'd0;
    assign ap_start   = (state_q == ISSUE) && (outst < MAX_OUTST_W);
    assign issue_fire = ap_start && ap_ready;
    assign done_fire  = active && ap_done && (done_q != num_q);
    assign issued_d   = issued_q + 16'(issue_fire);
    assign done_d     = done_q + 16'(done_fire);

`ifdef AP_CTRL_SEQ_TIMEOUT_EN
    logic [19:0] wd_q;
    logic [19:0] wd_inc;
    logic        timeout_err_q;

    assign wd_inc    = wd_q + 20'd1;
    assign wd_expire = active && !ap_ready && !ap_done && (wd_inc == 20'(TIMEOUT_CYCLES));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_q          <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (!active || ap_ready || ap_done) begin
                wd_q <= '0;
            end else begin
                wd_q <= wd_inc;
            end
            if (state_q == IDLE && start_req) begin
                timeout_err_q <= 1'b0;
            end else if (wd_expire) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign wd_expire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // NOTE: every register here is updated with <= so all next-state terms see pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            num_q    <= '0;
            issued_q <= '0;
            done_q   <= '0;
            cycles_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_req) begin
                        num_q    <= num_trans;
                        issued_q <= '0;
                        done_q   <= '0;
                        cycles_q <= '0;
                        state_q  <= (num_trans == 16'd0) ? FINISH : ISSUE;
                    end
                end
                ISSUE: begin
                    issued_q <= issued_d;
                    done_q   <= done_d;
                    cycles_q <= (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;
                    if (wd_expire) begin
                        state_q <= FINISH;
                    end else if (issue_fire && issued_d == num_q) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    done_q   <= done_d;
                    cycles_q <= (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;
                    if (wd_expire || done_d == num_q) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ap_continue  = active;
    assign busy         = (state_q != IDLE);
    assign finish       = (state_q == FINISH);
    assign issued_cnt   = issued_q;
    assign done_cnt     = done_q;
    assign total_cycles = cycles_q;

endmodule

// File: tb/tb_ap_ctrl_sequencer.sv
// Directed bench for ap_ctrl_sequencer: inputs change 1 time unit after each rising edge,
// outputs are sampled at that same point, well away from the next edge.
module tb_ap_ctrl_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_req = 1'b0;
    logic [15:0] num_trans = '0;
    logic        ap_start;
    logic        ap_ready = 1'b0;
    logic        ap_done = 1'b0;
    logic        ap_continue;
    logic        busy;
    logic        finish;
    logic [15:0] issued_cnt;
    logic [15:0] done_cnt;
    logic [31:0] total_cycles;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    ap_ctrl_sequencer #(.MAX_OUTST(2), .TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset(reset), .start_req(start_req), .num_trans(num_trans),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
        .busy(busy), .finish(finish), .issued_cnt(issued_cnt), .done_cnt(done_cnt),
        .total_cycles(total_cycles), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "time limit reached");
    end

    initial begin
        // Asynchronous reset, checked before any clock edge.
        #2 reset = 1'b0;
        #1;
        check("rst_state", {ap_start, ap_continue, busy, finish, timeout_err}, 32'd0);
        check("rst_cnts", {issued_cnt, done_cnt}, 32'd0);
        check("rst_cycles", total_cycles, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Batch of 3, ready with start, each done 5 cycles after its ready.
        num_trans = 16'd3;
        start_req = 1'b1;
        ap_ready  = 1'b1;
        tick();
        start_req = 1'b0;
        check("A_cont", 32'(ap_continue), 32'd1);
        for (int c = 0; c < 12; c++) begin
            ap_done = (c == 5 || c == 6 || c == 11);
            check($sformatf("A_start_c%0d", c), 32'(ap_start), (c < 2 || c == 6) ? 32'd1 : 32'd0);
            check($sformatf("A_busy_c%0d", c), 32'(busy), 32'd1);
            tick();
        end
        ap_done  = 1'b0;
        ap_ready = 1'b0;
        check("A_finish", 32'(finish), 32'd1);
        check("A_cnts", {issued_cnt, done_cnt}, {16'd3, 16'd3});
        check("A_cycles", total_cycles, 32'd12);
        tick();
        check("A_finish_off", 32'(finish), 32'd0);
        check("A_idle", 32'(busy), 32'd0);
        check("A_hold", {issued_cnt, done_cnt}, {16'd3, 16'd3});
        check("A_hold_cyc", total_cycles, 32'd12);

        // Empty batch goes straight to FINISH.
        num_trans = 16'd0;
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        check("B_finish", 32'(finish), 32'd1);
        check("B_start", 32'(ap_start), 32'd0);
        check("B_cnts", {issued_cnt, done_cnt}, 32'd0);
        check("B_cycles", total_cycles, 32'd0);
        tick();
        check("B_finish_off", {31'd0, finish}, 32'd0);
        check("B_idle", 32'(busy), 32'd0);

        // Ready and done in the same cycle with one outstanding.
        num_trans = 16'd3;
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        ap_ready  = 1'b1;
        tick();
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        check("C_cnts", {issued_cnt, done_cnt}, {16'd2, 16'd1});
        check("C_start", 32'(ap_start), 32'd1);
        tick();
        ap_ready = 1'b0;
        check("C_drain", {ap_start, busy, ap_continue}, 32'b011);
        check("C_issued", 32'(issued_cnt), 32'd3);
        ap_done = 1'b1;
        tick();
        tick();
        ap_done = 1'b0;
        check("C_finish", 32'(finish), 32'd1);
        check("C_done", 32'(done_cnt), 32'd3);
        check("C_cycles", total_cycles, 32'd5);
        tick();

        // Spurious done, saturating done_cnt, start_req while busy ignored.
        num_trans = 16'd2;
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        ap_done   = 1'b1;
        tick();
        check("D_spur_cnts", {issued_cnt, done_cnt}, {16'd0, 16'd1});
        check("D_spur_start", 32'(ap_start), 32'd1);
        ap_ready  = 1'b1;
        start_req = 1'b1;
        num_trans = 16'd9;
        tick();
        start_req = 1'b0;
        check("D_cnts", {issued_cnt, done_cnt}, {16'd1, 16'd2});
        tick();
        ap_ready = 1'b0;
        ap_done  = 1'b0;
        check("D_sat", {issued_cnt, done_cnt}, {16'd2, 16'd2});
        check("D_drain", {ap_start, busy}, 32'b01);
        tick();
        check("D_finish", 32'(finish), 32'd1);
        tick();
        check("D_idle", 32'(busy), 32'd0);

        // Reset in the middle of DRAIN with issued=4, done=2.
        num_trans = 16'd4;
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        ap_ready  = 1'b1;
        tick();
        tick();
        ap_done = 1'b1;
        check("E_stall", 32'(ap_start), 32'd0);
        tick();
        tick();
        ap_done = 1'b0;
        tick();
        ap_ready = 1'b0;
        check("E_pre", {issued_cnt, done_cnt}, {16'd4, 16'd2});
        check("E_pre_drain", {ap_start, busy}, 32'b01);
        #2 reset = 1'b0;
        #1;
        check("E_rst_flags", {ap_start, ap_continue, busy, finish, timeout_err}, 32'd0);
        check("E_rst_cnts", {issued_cnt, done_cnt}, 32'd0);
        check("E_rst_cycles", total_cycles, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("E_no_finish", {busy, finish}, 32'd0);
        num_trans = 16'd1;
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        ap_ready  = 1'b1;
        tick();
        ap_ready = 1'b0;
        ap_done  = 1'b1;
        tick();
        ap_done = 1'b0;
        check("E_finish", 32'(finish), 32'd1);
        check("E_cnts", {issued_cnt, done_cnt}, {16'd1, 16'd1});
        check("E_cycles", total_cycles, 32'd2);
        tick();

`ifdef AP_CTRL_SEQ_TIMEOUT_EN
        // Kernel silent: watchdog forces FINISH after 16 ISSUE cycles.
        num_trans = 16'd5;
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        for (int c = 0; c < 16; c++) begin
            check($sformatf("F_wait_c%0d", c), {busy, timeout_err}, 32'b10);
            tick();
        end
        check("F_finish", {finish, timeout_err}, 32'b11);
        check("F_cnts", {issued_cnt, done_cnt}, 32'd0);
        check("F_cycles", total_cycles, 32'd16);
        tick();
        check("F_sticky", {busy, timeout_err}, 32'b01);
        num_trans = 16'd0;
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        check("F_clear", {finish, timeout_err}, 32'b10);
        tick();
`else
        // Without the watchdog a silent kernel just keeps the batch open.
        num_trans = 16'd1;
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        repeat (20) tick();
        check("F_open", {busy, timeout_err, finish}, 32'b100);
        ap_ready = 1'b1;
        tick();
        ap_ready = 1'b0;
        ap_done  = 1'b1;
        tick();
        ap_done = 1'b0;
        check("F_finish", {finish, timeout_err}, 32'b10);
        check("F_cycles", total_cycles, 32'd22);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
